imem_loader: RTL and testbench

//  Writer side of the instruction-memory path: fetch only reads imem; this block writes it.

---
 rtl/imem_loader_pkg.sv | 10 +
 rtl/imem_loader_byte_packer.sv | 51 +++++
 rtl/imem_loader.sv | 120 ++++++++++++
 tb/tb_imem_loader.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and sizing for the instruction-memory loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {IDLE, ASSEMBLE, WRITE, DONE, ERROR} loader_state_e;

   localparam int BYTES_PER_WORD = 4;
   localparam int WCNT_W         = 16;
   localparam int IDX_W          = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a byte stream little-endian into words; a last byte closes the word early,
// leaving the unfilled upper bytes at zero.
module imem_loader_byte_packer
   import imem_loader_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clear_i,
   input  logic                          byte_fire_i,
   input  logic [7:0]                    byte_data_i,
   input  logic                          byte_last_i,
   output logic                          word_valid_o,
   output logic [BYTES_PER_WORD*8-1:0]   word_o
);

   logic [IDX_W-1:0]              idx_q, idx_d;
   logic [BYTES_PER_WORD*8-1:0]   acc_q, acc_d;

   // acc_q only ever holds bytes below idx_q, so the upper lanes are already zero
   always_comb begin
      word_o                  = acc_q;
      word_o[8*idx_q +: 8]    = byte_data_i;
      word_valid_o            = byte_fire_i & ((idx_q == IDX_W'(BYTES_PER_WORD-1)) | byte_last_i);
   end

   always_comb begin
      idx_d = idx_q;
      acc_d = acc_q;
      if (clear_i) begin
         idx_d = '0;
         acc_d = '0;
      end else if (word_valid_o) begin
         idx_d = '0;
         acc_d = '0;
      end else if (byte_fire_i) begin
         idx_d = idx_q + 1'b1;
         acc_d = word_o;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_q <= '0;
         acc_q <= '0;
      end else begin
         idx_q <= idx_d;
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory writer: byte stream in, word writes at BASE_ADDR + 4*n out.
// Optional XOR checksum of written words when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int                AWIDTH    = 32,
   parameter int                DWIDTH    = 32,
   parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h01000000,
   parameter int                MAX_WORDS = 1024
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic                byte_valid_i,
   input  logic [7:0]          byte_data_i,
   input  logic                byte_last_i,
   output logic                byte_ready_o,
   output logic [AWIDTH-1:0]   addr_o,
   output logic [DWIDTH-1:0]   data_o,
   output logic                write_en_o,
   output logic                read_en_o,
   output logic                busy_o,
   output logic                done_o,
   output logic                err_o,
   output logic                core_rst_o,
   output logic [WCNT_W-1:0]   words_written_o,
   output logic [DWIDTH-1:0]   checksum_o
);

   loader_state_e        state_q, state_d;
   logic [WCNT_W-1:0]    words_q;
   logic [AWIDTH-1:0]    addr_q;
   logic [DWIDTH-1:0]    data_q;
   logic                 last_q;
   logic [DWIDTH-1:0]    word;
   logic                 word_valid, byte_fire, at_cap, overflow, load_start;

   assign byte_ready_o = (state_q == ASSEMBLE);
   assign byte_fire    = byte_valid_i & byte_ready_o;
   assign at_cap       = (words_q == WCNT_W'(MAX_WORDS));
   assign overflow     = byte_fire & at_cap;
   assign load_start   = start_i & ((state_q == IDLE) | (state_q == DONE) | (state_q == ERROR));

   // a byte arriving with the image already full is dropped, not packed
   imem_loader_byte_packer u_packer (
      .clk          (clk),
      .rst          (rst),
      .clear_i      (load_start),
      .byte_fire_i  (byte_fire & ~at_cap),
      .byte_data_i  (byte_data_i),
      .byte_last_i  (byte_last_i),
      .word_valid_o (word_valid),
      .word_o       (word)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, DONE, ERROR: if (start_i) state_d = ASSEMBLE;
         ASSEMBLE: begin
            if (overflow)        state_d = ERROR;
            else if (word_valid) state_d = WRITE;
         end
         WRITE:   state_d = last_q ? DONE : ASSEMBLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         words_q <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         if (load_start) begin
            words_q <= '0;
            last_q  <= 1'b0;
         end else if ((state_q == WRITE) && !at_cap) begin
            words_q <= words_q + 1'b1;
         end
         // word index is captured before the increment that follows the strobe
         if (word_valid) begin
            data_q <= word;
            addr_q <= BASE_ADDR + (AWIDTH'(words_q) << 2);
            last_q <= byte_last_i;
         end
      end
   end

   assign addr_o          = addr_q;
   assign data_o          = data_q;
   assign write_en_o      = (state_q == WRITE);
   assign read_en_o       = 1'b0;
   assign busy_o          = (state_q == ASSEMBLE) | (state_q == WRITE);
   assign done_o          = (state_q == DONE);
   assign err_o           = (state_q == ERROR);
   assign core_rst_o      = busy_o;
   assign words_written_o = words_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [DWIDTH-1:0] csum_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)            csum_q <= '0;
      else if (load_start) csum_q <= '0;
      else if (write_en_o) csum_q <= csum_q ^ data_q;
   end

   assign checksum_o = csum_q;
`else
   assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader against a byte-queue reference model.
module tb_imem_loader;

   localparam logic [31:0] BASE = 32'h01000000;
   localparam int          MAXW = 4;

   typedef logic [7:0] bq_t [$];

   logic        clk = 1'b0, rst = 1'b0, start_i = 1'b0;
   logic        byte_valid_i = 1'b0, byte_last_i = 1'b0;
   logic [7:0]  byte_data_i = 8'h00;
   logic        byte_ready_o, write_en_o, read_en_o, busy_o, done_o, err_o, core_rst_o;
   logic [31:0] addr_o, data_o, checksum_o;
   logic [15:0] words_written_o;

   int          checks = 0, failures = 0, ready_bad = 0;
   logic [63:0] wq [$];
   logic [63:0] eq [$];

   imem_loader #(.MAX_WORDS(MAXW)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .byte_valid_i(byte_valid_i),
      .byte_data_i(byte_data_i), .byte_last_i(byte_last_i), .byte_ready_o(byte_ready_o),
      .addr_o(addr_o), .data_o(data_o), .write_en_o(write_en_o), .read_en_o(read_en_o),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .core_rst_o(core_rst_o),
      .words_written_o(words_written_o), .checksum_o(checksum_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (write_en_o) begin
         wq.push_back({addr_o, data_o});
         if (byte_ready_o) ready_bad++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   // Reference: groups of 4 bytes, little-endian, zero-padded tail, capped at MAXW words.
   task automatic model_writes(input bq_t b);
      logic [31:0] w;
      eq.delete();
      for (int n = 0; 4*n < b.size() && n < MAXW; n++) begin
         w = 32'h0;
         for (int k = 0; k < 4; k++)
            if (4*n + k < b.size()) w[8*k +: 8] = b[4*n + k];
         eq.push_back({BASE + 32'(4*n), w});
      end
   endtask

   function automatic logic [31:0] exp_csum();
      logic [31:0] c = 32'h0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      foreach (eq[i]) c = c ^ eq[i][31:0];
`endif
      return c;
   endfunction

   task automatic pulse_start();
      @(negedge clk); start_i = 1'b1;
      @(negedge clk); start_i = 1'b0;
   endtask

   task automatic send_bytes(input bq_t b, input bit mark_last, input bit gaps);
      for (int i = 0; i < b.size(); i++) begin
         int t;
         @(negedge clk);
         if (gaps) begin
            byte_valid_i = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         byte_valid_i = 1'b1;
         byte_data_i  = b[i];
         byte_last_i  = mark_last && (i == b.size() - 1);
         t = 0;
         while (!byte_ready_o && t < 50) begin @(negedge clk); t++; end
         if (t >= 50) begin
            checks++; failures++;
            $display("FAIL handshake_timeout byte=%0d ready=%b required 1", i, byte_ready_o);
            byte_valid_i = 1'b0;
            return;
         end
         @(posedge clk);
      end
      @(negedge clk);
      byte_valid_i = 1'b0;
      byte_last_i  = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (busy_o && t < 50) begin @(negedge clk); t++; end
      checks++;
      if (busy_o) begin failures++; $display("FAIL idle_timeout busy_o=%b required 0", busy_o); end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({byte_ready_o, addr_o, data_o, write_en_o, read_en_o, busy_o, done_o, err_o,
           core_rst_o, words_written_o, checksum_o} !== '0) begin
         failures++;
         $display("FAIL reset_outputs addr=%h data=%h busy=%b words=%0d csum=%h required all 0",
                  addr_o, data_o, busy_o, words_written_o, checksum_o);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({byte_ready_o, busy_o, done_o} !== 3'b000) begin
         failures++; $display("FAIL idle_after_reset got=%b required 000", {byte_ready_o, busy_o, done_o});
      end
   endtask

   task automatic test_basic();
      bq_t b;
      b = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      pulse_start();
      checks++;
      if ({busy_o, core_rst_o, byte_ready_o} !== 3'b111) begin
         failures++; $display("FAIL basic_busy got=%b required 111", {busy_o, core_rst_o, byte_ready_o});
      end
      wq.delete(); model_writes(b);
      send_bytes(b, 1'b1, 1'b0);
      checks++;
      if ({write_en_o, addr_o, data_o} !== {1'b1, BASE + 32'd4, 32'h00100093}) begin
         failures++;
         $display("FAIL basic_latency we=%b addr=%h data=%h required 1 %h 00100093", write_en_o, addr_o, data_o, BASE + 32'd4);
      end
      wait_idle();
      checks++;
      if (wq.size() != eq.size()) begin failures++; $display("FAIL basic_count got=%0d required %0d", wq.size(), eq.size()); end
      for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
         checks++;
         if (wq[i] !== eq[i]) begin failures++; $display("FAIL basic_write%0d got=%h required %h", i, wq[i], eq[i]); end
      end
      checks++;
      if ({done_o, err_o, busy_o, words_written_o} !== {3'b100, 16'd2}) begin
         failures++; $display("FAIL basic_status done=%b err=%b busy=%b words=%0d required 1 0 0 2", done_o, err_o, busy_o, words_written_o);
      end
      checks++;
      if (checksum_o !== exp_csum()) begin failures++; $display("FAIL basic_csum got=%h required %h", checksum_o, exp_csum()); end
   endtask

   task automatic test_partial();
      bq_t b;
      b = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hAA};
      pulse_start();
      wq.delete(); model_writes(b);
      send_bytes(b, 1'b1, 1'b0);
      wait_idle();
      checks++;
      if (wq.size() != eq.size()) begin failures++; $display("FAIL partial_count got=%0d required %0d", wq.size(), eq.size()); end
      for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
         checks++;
         if (wq[i] !== eq[i]) begin failures++; $display("FAIL partial_write%0d got=%h required %h", i, wq[i], eq[i]); end
      end
      checks++;
      if ({done_o, words_written_o} !== {1'b1, 16'd2}) begin
         failures++; $display("FAIL partial_status done=%b words=%0d required 1 2", done_o, words_written_o);
      end
   endtask

   task automatic test_random_gaps();
      bq_t b;
      for (int i = 0; i < 12; i++) b.push_back(8'($urandom));
      pulse_start();
      wq.delete(); model_writes(b); ready_bad = 0;
      send_bytes(b, 1'b1, 1'b1);
      wait_idle();
      checks++;
      if (wq.size() != eq.size()) begin failures++; $display("FAIL gaps_count got=%0d required %0d", wq.size(), eq.size()); end
      for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
         checks++;
         if (wq[i] !== eq[i]) begin failures++; $display("FAIL gaps_write%0d got=%h required %h", i, wq[i], eq[i]); end
      end
      checks++;
      if (ready_bad != 0) begin failures++; $display("FAIL gaps_ready_in_write got=%0d required 0", ready_bad); end
      checks++;
      if (checksum_o !== exp_csum()) begin failures++; $display("FAIL gaps_csum got=%h required %h", checksum_o, exp_csum()); end
   endtask

   task automatic test_overflow();
      bq_t b;
      for (int i = 0; i < 4*MAXW + 1; i++) b.push_back(8'($urandom));
      pulse_start();
      wq.delete(); model_writes(b);
      send_bytes(b, 1'b1, 1'b0);
      wait_idle();
      checks++;
      if (wq.size() != eq.size()) begin failures++; $display("FAIL ovf_count got=%0d required %0d", wq.size(), eq.size()); end
      for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
         checks++;
         if (wq[i] !== eq[i]) begin failures++; $display("FAIL ovf_write%0d got=%h required %h", i, wq[i], eq[i]); end
      end
      checks++;
      if ({err_o, done_o, busy_o, words_written_o} !== {3'b100, 16'(MAXW)}) begin
         failures++; $display("FAIL ovf_status err=%b done=%b busy=%b words=%0d required 1 0 0 %0d", err_o, done_o, busy_o, words_written_o, MAXW);
      end
      pulse_start();
      checks++;
      if ({err_o, busy_o, words_written_o, checksum_o} !== {2'b01, 16'd0, 32'd0}) begin
         failures++; $display("FAIL ovf_restart err=%b busy=%b words=%0d csum=%h required 0 1 0 0", err_o, busy_o, words_written_o, checksum_o);
      end
      b.delete(); b.push_back(8'h5C);
      wq.delete(); model_writes(b);
      send_bytes(b, 1'b1, 1'b0);
      wait_idle();
      checks++;
      if (wq.size() != 1 || wq[0] !== eq[0] || done_o !== 1'b1) begin
         failures++; $display("FAIL ovf_reload writes=%0d done=%b required 1 write %h done 1", wq.size(), done_o, eq[0]);
      end
   endtask

   task automatic test_reset_abort();
      bq_t b;
      for (int i = 0; i < 6; i++) b.push_back(8'($urandom));
      pulse_start();
      wq.delete(); model_writes(b);
      send_bytes(b, 1'b0, 1'b0);
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({byte_ready_o, addr_o, data_o, write_en_o, busy_o, done_o, err_o, core_rst_o,
           words_written_o, checksum_o} !== '0) begin
         failures++; $display("FAIL abort_async addr=%h data=%h busy=%b words=%0d required all 0", addr_o, data_o, busy_o, words_written_o);
      end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (wq.size() != 1 || wq[0] !== eq[0]) begin
         failures++; $display("FAIL abort_writes count=%0d required 1 (word %h)", wq.size(), eq[0]);
      end
      b.delete();
      for (int i = 0; i < 4; i++) b.push_back(8'($urandom));
      pulse_start();
      wq.delete(); model_writes(b);
      send_bytes(b, 1'b1, 1'b0);
      wait_idle();
      checks++;
      if (wq.size() != 1 || wq[0] !== eq[0] || words_written_o !== 16'd1) begin
         failures++; $display("FAIL abort_reload count=%0d words=%0d required 1 write %h words 1", wq.size(), words_written_o, eq[0]);
      end
   endtask

   task automatic test_back_to_back();
      bq_t b;
      for (int i = 0; i < 4; i++) b.push_back(8'($urandom));
      wq.delete(); model_writes(b);
      @(negedge clk);
      start_i = 1'b1; byte_valid_i = 1'b1; byte_data_i = b[0]; byte_last_i = 1'b0;
      @(negedge clk);
      start_i = 1'b0; byte_valid_i = 1'b0;
      checks++;
      if ({busy_o, done_o, words_written_o} !== {2'b10, 16'd0}) begin
         failures++; $display("FAIL b2b_start busy=%b done=%b words=%0d required 1 0 0", busy_o, done_o, words_written_o);
      end
      send_bytes(b, 1'b1, 1'b0);
      wait_idle();
      checks++;
      if (wq.size() != 1 || wq[0] !== eq[0]) begin
         failures++; $display("FAIL b2b_write count=%0d first=%h required 1 %h", wq.size(), (wq.size() > 0) ? wq[0] : 64'h0, eq[0]);
      end
   endtask

   task automatic test_checksum();
      bq_t b;
      logic [31:0] req;
      b = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
      req = 32'h00100080;
`else
      req = 32'h0;
`endif
      pulse_start();
      wq.delete(); model_writes(b);
      send_bytes(b, 1'b1, 1'b0);
      wait_idle();
      checks++;
      if (checksum_o !== req || checksum_o !== exp_csum()) begin
         failures++; $display("FAIL csum_value got=%h required %h", checksum_o, req);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_partial();
      test_random_gaps();
      test_overflow();
      test_reset_abort();
      test_back_to_back();
      test_checksum();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
